alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that computes the unsigned 8x8 product (low byte) of two operands using the shared 8-bit ALU's ADD and SHL operations, one ALU operation per cycle.
- Owns the ALU input bus while a multiply is in progress. When idle, passes the main datapath's ALU controls straight through.
- Sits between the decode/datapath stage and the ALU. Asserts busy so the pipeline can stall.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the multiply sequencer state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SHL  = 4'b0011;
    localparam logic [3:0] OP_LT   = 4'b0100;
    localparam logic [3:0] OP_EQ0  = 4'b0101;
    localparam logic [3:0] OP_CMP4 = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier that borrows the shared ALU one operation per cycle.
//
// state | meaning
// IDLE  | ALU bus passes datapath controls through; ready for a new multiply
// ADD   | acc += mcand via ALU ADD
// SHIFT | mcand <<= 1 via ALU SHL, multiplier consumes one bit
// DONE  | product/overflow valid, one-cycle done pulse
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic             start_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             mul_overflow,
    input  logic [3:0]       dp_opcode,
    input  logic [WIDTH-1:0] dp_rs1,
    input  logic [WIDTH-1:0] dp_rs2,
    input  logic [1:0]       dp_constant,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [1:0]       alu_constant,
    input  logic [WIDTH-1:0] alu_out
);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             mul_overflow_q, mul_overflow_d;

    // Next-state, datapath updates and ALU bus ownership.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        mcand_d        = mcand_q;
        mplr_d         = mplr_q;
        ovf_d          = ovf_q;
        product_d      = product_q;
        mul_overflow_d = mul_overflow_q;
        alu_opcode     = dp_opcode;
        alu_rs1        = dp_rs1;
        alu_rs2        = dp_rs2;
        alu_constant   = dp_constant;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    mcand_d = mul_a;
                    mplr_d  = mul_b;
                    ovf_d   = 1'b0;
                    if (mul_b == '0)
                        state_d = DONE;
                    else if (mul_b[0])
                        state_d = ADD;
                    else
                        state_d = SHIFT;
                end
            end
            ADD: begin
                alu_opcode   = OP_ADD;
                alu_rs1      = acc_q;
                alu_rs2      = mcand_q;
                alu_constant = 2'b00;
                acc_d        = alu_out;
                // A smaller sum than the old accumulator means the add wrapped.
                if (alu_out < acc_q)
                    ovf_d = 1'b1;
                state_d = ((mplr_q >> 1) == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                alu_opcode   = OP_SHL;
                alu_rs1      = mcand_q;
                alu_rs2      = '0;
                alu_constant = 2'b00;
                mcand_d      = alu_out;
                mplr_d       = mplr_q >> 1;
                // Losing the top bit only matters if a later multiplier bit will add it.
                if (mcand_q[WIDTH-1] && (mplr_d != '0))
                    ovf_d = 1'b1;
                state_d = mplr_d[0] ? ADD : SHIFT;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // DONE is only ever entered from another state, so this captures on entry.
        if (state_d == DONE) begin
            product_d      = acc_d;
            mul_overflow_d = ovf_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplr_q         <= '0;
            ovf_q          <= 1'b0;
            product_q      <= '0;
            mul_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            mcand_q        <= mcand_d;
            mplr_q         <= mplr_d;
            ovf_q          <= ovf_d;
            product_q      <= product_d;
            mul_overflow_q <= mul_overflow_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign busy         = (state_q == ADD) || (state_q == SHIFT);
    assign done         = (state_q == DONE);
    assign product      = product_q;
    assign mul_overflow = mul_overflow_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer against an arithmetic reference model.
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] mul_a, mul_b;
    logic         start_ready, busy, done, mul_overflow;
    logic [W-1:0] product;
    logic [3:0]   dp_opcode, alu_opcode;
    logic [W-1:0] dp_rs1, dp_rs2, alu_rs1, alu_rs2, alu_out;
    logic [1:0]   dp_constant, alu_constant;

    int n_chk  = 0;
    int n_pass = 0;

    alu_mul_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mul_a(mul_a), .mul_b(mul_b),
        .start_ready(start_ready), .busy(busy), .done(done),
        .product(product), .mul_overflow(mul_overflow),
        .dp_opcode(dp_opcode), .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_constant(dp_constant),
        .alu_opcode(alu_opcode), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_constant(alu_constant), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        alu_out = '0;
        case (alu_opcode)
            OP_ADD:  alu_out = alu_rs1 + alu_rs2;
            OP_ADDI: alu_out = alu_rs1 + W'(alu_constant);
            OP_SUB:  alu_out = alu_rs1 - alu_rs2;
            OP_SHL:  alu_out = alu_rs1 << 1;
            OP_LT:   alu_out = W'(alu_rs1 < alu_rs2);
            OP_EQ0:  alu_out = W'(alu_rs1 == '0);
            OP_XOR:  alu_out = alu_rs1 ^ alu_rs2;
            OP_AND:  alu_out = alu_rs1 & alu_rs2;
            OP_OR:   alu_out = alu_rs1 | alu_rs2;
            OP_NOT:  alu_out = ~alu_rs1;
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic rand_dp();
        dp_opcode   = 4'($urandom);
        dp_rs1      = W'($urandom);
        dp_rs2      = W'($urandom);
        dp_constant = 2'($urandom);
    endtask

    // Runs one multiply; noisy adds ignored start pulses and operand churn while busy.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
        int unsigned full;
        logic [3:0]  ops[$];
        int          msb, cyc, busy_cnt, exp_lat;
        bit          got_done;
        logic [W-1:0] held;

        full = int'(a) * int'(b);
        msb = -1;
        for (int k = 0; k < W; k++) if (b[k]) msb = k;
        for (int k = 0; k <= msb; k++) begin
            if (k > 0) ops.push_back(OP_SHL);
            if (b[k])  ops.push_back(OP_ADD);
        end
        exp_lat = ops.size() + 1;

        @(negedge clk);
        chk("start_ready_idle", 32'(start_ready), 1);
        start = 1'b1;
        mul_a = a;
        mul_b = b;
        @(negedge clk);
        start = 1'b0;
        if (noisy) begin
            mul_a = W'($urandom);
            mul_b = W'($urandom);
        end
        cyc = 0;
        busy_cnt = 0;
        got_done = 1'b0;
        while (cyc < 40 && !got_done) begin
            cyc++;
            if (busy) begin
                if (busy_cnt < ops.size())
                    chk("busy_opcode", 32'(alu_opcode), 32'(ops[busy_cnt]));
                else
                    chk("extra_busy_cycle", 32'(busy), 0);
                chk("busy_constant", 32'(alu_constant), 0);
                busy_cnt++;
            end
            if (done) got_done = 1'b1;
            rand_dp();
            start = noisy && busy && ($urandom_range(0, 1) == 1);
            #1;
            if (!busy)
                chk("passthrough", 32'({alu_opcode, alu_rs1, alu_rs2, alu_constant}),
                    32'({dp_opcode, dp_rs1, dp_rs2, dp_constant}));
            if (!got_done) @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(got_done), 1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(ops.size()));
        chk("product", 32'(product), full & 32'hFF);
        chk("overflow", 32'(mul_overflow), 32'(full > 255));
        held = product;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("back_to_idle", 32'(start_ready), 1);
        chk("product_held", 32'(product), 32'(held));
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        mul_a = '0;
        mul_b = '0;
        rand_dp();
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_product", 32'(product), 0);
        chk("rst_overflow", 32'(mul_overflow), 0);
        reset = 1'b0;

        run_mul(8'd3,   8'd5,   1'b0);
        run_mul(8'd200, 8'd0,   1'b0);
        run_mul(8'd16,  8'd16,  1'b0);
        run_mul(8'd15,  8'd17,  1'b0);
        run_mul(8'd200, 8'd3,   1'b0);
        run_mul(8'd255, 8'd255, 1'b0);

        @(negedge clk);
        dp_opcode   = OP_XOR;
        dp_rs1      = 8'd7;
        dp_rs2      = 8'd6;
        dp_constant = 2'b00;
        #1;
        chk("passthru_xor", 32'(alu_out), 1);

        run_mul(8'd3, 8'd5, 1'b1);

        // Abort a multiply in its first SHIFT, with start also raised alongside reset.
        @(negedge clk);
        start = 1'b1;
        mul_a = 8'd3;
        mul_b = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_shift", 32'(alu_opcode), 32'(OP_SHL));
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_start_ready", 32'(start_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_product", 32'(product), 0);
        chk("abort_overflow", 32'(mul_overflow), 0);
        reset = 1'b0;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("abort_no_activity", 32'(pulses), 0);
        run_mul(8'd2, 8'd2, 1'b0);

        for (int i = 0; i < 60; i++)
            run_mul(W'($urandom), W'($urandom), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
